// File: rtl/muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// muldiv_ctrl
//   Sequencer for the HI/LO arithmetic resource in the EX stage.
//   MULT/MULTU run on an internal shift-add multiplier that produces one
//   product bit per cycle. DIV/DIVU are handed to an external iterative
//   divider through its start/ready/annul handshake. While either one is
//   running, the pipeline is held through stallreq_ex. When the 64-bit result
//   is ready, a single-cycle HI/LO write is issued toward MEM/WB.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req_valid/op      mul/div request from EX (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   req_src1/src2     rs / rt operands
//   flush             cancel the in-flight operation, suppress the HI/LO write
//   div_*             handshake with the external divider
//   stallreq_ex       stall request to CTRL
//   hilo_we, hi_o, lo_o  one-cycle HI/LO write strobe and data
//   busy              sequencer is not idle
// ----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int MUL_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stallreq_ex,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy
);

    localparam int CNT_W = $clog2(MUL_STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Magnitude of a two's-complement operand; 32'h80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        logic signed [31:0] n;
        n = -v;
        return v[31] ? n : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [63:0]      mcand_q,  mcand_d;   // multiplicand, pre-shifted by cnt
    logic [31:0]      mplier_q, mplier_d;
    logic [63:0]      prod_q,   prod_d;    // accumulator, then final HI/LO result
    logic             neg_q,    neg_d;
    logic [31:0]      op1_q,    op1_d;
    logic [31:0]      op2_q,    op2_d;
    logic             dsgn_q,   dsgn_d;
    logic [63:0]      sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        dsgn_d   = dsgn_q;
        sum      = prod_q + (mplier_q[0] ? mcand_q : 64'd0);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (!req_op[1]) begin
                        // MULT works on magnitudes and fixes the sign at the end
                        neg_d    = ~req_op[0] & (req_src1[31] ^ req_src2[31]);
                        mcand_d  = {32'd0, req_op[0] ? req_src1 : mag32(req_src1)};
                        mplier_d = req_op[0] ? req_src2 : mag32(req_src2);
                        prod_d   = 64'd0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        op1_d  = req_src1;
                        op2_d  = req_src2;
                        dsgn_d = ~req_op[0];
                        if (req_src2 == 32'd0) begin
                            // divide by zero never reaches the divider
                            prod_d  = 64'd0;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DIV;
                        end
                    end
                end
            end
            S_MUL: begin
                prod_d   = sum;
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    prod_d  = neg_q ? neg64(sum) : sum;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                if (div_ready_i) begin
                    prod_d  = div_result_i;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            neg_q    <= 1'b0;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            dsgn_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            dsgn_q   <= dsgn_d;
        end
    end

    logic in_div, in_done;
    assign in_div  = (state_q == S_DIV);
    assign in_done = (state_q == S_DONE);

    assign div_start_o  = in_div & ~flush;
    assign div_annul_o  = in_div & flush;
    assign div_signed_o = in_div & dsgn_q;
    assign div_op1_o    = in_div ? op1_q : 32'd0;
    assign div_op2_o    = in_div ? op2_q : 32'd0;

    // rst gates the stall so every output is 0 while reset is asserted,
    // even if EX keeps req_valid high
    assign stallreq_ex = rst & (((state_q == S_IDLE) & req_valid) |
                                (state_q == S_MUL) | in_div);

    assign hilo_we = in_done & ~flush;
    assign hi_o    = hilo_we ? prod_q[63:32] : 32'd0;
    assign lo_o    = hilo_we ? prod_q[31:0]  : 32'd0;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: scoreboarded HI/LO writes plus a simple
// iterative-divider responder model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        flush;
    logic        div_start_o, div_signed_o, div_annul_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        stallreq_ex, hilo_we, busy;
    logic [31:0] hi_o, lo_o;

    int n_tests = 0;
    int n_fail  = 0;
    int annul_cnt = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_STEPS(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_annul_o(div_annul_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .stallreq_ex(stallreq_ex), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
        logic signed [31:0] sq, sr;
        if (sgn) begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    // Divider responder: ready pulses once after start has been held 34 edges.
    int dcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt <= 0; div_ready_i <= 1'b0; div_result_i <= 64'd0;
        end else if (!div_start_o) begin
            dcnt <= 0; div_ready_i <= 1'b0;
        end else begin
            dcnt <= dcnt + 1;
            div_ready_i <= (dcnt == 33);
            if (dcnt == 33) div_result_i <= div_model(div_op1_o, div_op2_o, div_signed_o);
        end
    end

    // Scoreboard: every HI/LO write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && div_annul_o) annul_cnt++;
        if (rst && hilo_we) begin
            check("write_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) check("hilo", {hi_o, lo_o}, sb_q.pop_front());
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, output int lat, output int stalls,
                          output int rdy_cyc, output int starts, output logic sgn);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
        sb_q.push_back(exp);
        lat = -1; rdy_cyc = -1; starts = 0; sgn = 1'b0;
        @(negedge clk);
        stalls = stallreq_ex ? 1 : 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (div_ready_i) rdy_cyc = c;
            if (div_start_o) begin starts++; sgn = div_signed_o; end
            if (hilo_we) begin lat = c; break; end
            if (stallreq_ex) stalls++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    int   lat, stalls, rdy, starts, cnt;
    logic sgn;

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_src1 = 32'd0; req_src2 = 32'd0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 64'({div_start_o, div_signed_o, div_annul_o, stallreq_ex, hilo_we, busy}), 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_divops", {div_op1_o, div_op2_o}, 64'd0);
        rst = 1'b1;

        run_op(2'b01, 32'd3, 32'd5, 64'd15, lat, stalls, rdy, starts, sgn);
        check("multu_lat", 64'(lat), 64'd33);
        check("multu_stall_cycles", 64'(stalls), 64'd33);

        run_op(2'b00, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, lat, stalls, rdy, starts, sgn);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, lat, stalls, rdy, starts, sgn);
        run_op(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, lat, stalls, rdy, starts, sgn);
        run_op(2'b00, 32'hFFFFFFF9, 32'hFFFFFFF7, 64'd63, lat, stalls, rdy, starts, sgn);
        run_op(2'b00, 32'd0, 32'hFFFFFFFB, 64'd0, lat, stalls, rdy, starts, sgn);
        check("mult_lat", 64'(lat), 64'd33);

        run_op(2'b10, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, lat, stalls, rdy, starts, sgn);
        check("div_signed", 64'(sgn), 64'd1);
        check("div_started", 64'(starts > 0), 64'd1);
        check("div_lat_after_ready", 64'(lat), 64'(rdy + 1));

        run_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, lat, stalls, rdy, starts, sgn);
        check("divu_signed", 64'(sgn), 64'd0);
        check("divu_lat_after_ready", 64'(lat), 64'(rdy + 1));

        run_op(2'b11, 32'd9, 32'd0, 64'd0, lat, stalls, rdy, starts, sgn);
        check("div0_lat", 64'(lat), 64'd1);
        check("div0_no_start", 64'(starts), 64'd0);

        // flush in the middle of a division
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b10; req_src1 = 32'd100; req_src2 = 32'd3;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 10; c++) begin
            @(negedge clk);
            if (div_start_o) cnt++;
        end
        check("flush_reached_div", 64'(cnt), 64'd10);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_annul", 64'({div_annul_o, div_start_o}), 64'b10);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        check("flush_idle", 64'({busy, div_annul_o, div_start_o}), 64'd0);
        repeat (50) @(posedge clk);
        check("annul_pulses", 64'(annul_cnt), 64'd1);

        // reset in the middle of a multiply
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'd7; req_src2 = 32'd7;
        repeat (6) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("midrst_ctl", 64'({div_start_o, div_signed_o, div_annul_o, stallreq_ex, hilo_we, busy}), 64'd0);
        check("midrst_hilo", {hi_o, lo_o}, 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        repeat (40) @(posedge clk);
        check("midrst_annul", 64'(annul_cnt), 64'd1);

        run_op(2'b01, 32'd2, 32'd2, 64'd4, lat, stalls, rdy, starts, sgn);
        check("after_rst_lat", 64'(lat), 64'd33);

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
